// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order integer execute path: ALU opcode
// enum, default tag widths and the RR/EX pipeline payload layouts.
package ooo_pkg;

   localparam int DATA_W            = 32;
   localparam int DEF_PHYS_REG_BITS = 6;
   localparam int DEF_ROB_IDX_BITS  = 4;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   // Issued micro-op as held in the register-read stage.
   typedef struct packed {
      alu_op_e                       op;
      logic                          alu_src;
      logic [DATA_W-1:0]             imm;
      logic [DEF_PHYS_REG_BITS-1:0]  rs1;
      logic [DEF_PHYS_REG_BITS-1:0]  rs2;
      logic [DEF_PHYS_REG_BITS-1:0]  rd;
      logic [DEF_ROB_IDX_BITS-1:0]   rob_idx;
   } rr_payload_t;

   // Micro-op with resolved operands as held in the execute stage.
   typedef struct packed {
      alu_op_e                       op;
      logic [DATA_W-1:0]             opa;
      logic [DATA_W-1:0]             opb;
      logic [DEF_PHYS_REG_BITS-1:0]  rd;
      logic [DEF_ROB_IDX_BITS-1:0]   rob_idx;
   } ex_payload_t;

   // Physical register 0 is hardwired to zero regardless of PRF contents.
   function automatic logic [DATA_W-1:0] preg_value(
      input logic [DEF_PHYS_REG_BITS-1:0] addr,
      input logic [DATA_W-1:0]            data
   );
      return (addr == '0) ? '0 : data;
   endfunction

endpackage

// File: rtl/ooo_alu.sv
// Purely combinational 32-bit integer ALU shared by execution units.
// Unused opcodes (10-15) return zero; shifts use b[4:0].
module ooo_alu
   import ooo_pkg::*;
(
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);

   logic signed [DATA_W-1:0] a_s;
   logic signed [DATA_W-1:0] b_s;
   logic [4:0]               shamt;

   assign a_s   = a;
   assign b_s   = b;
   assign shamt = b[4:0];

   // Select the operation result; wrapping arithmetic, no flags.
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_SLL:  result = a << shamt;
         ALU_SRL:  result = a >> shamt;
         ALU_SRA:  result = a_s >>> shamt;
         ALU_SLT:  result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
         ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage (RR -> EX) integer execute back-end with CDB valid/ready
// output and issue-queue wake-up broadcast.
// Optional feature macro EARLY_WAKEUP_EN: wake-up is raised when an op
// leaves RR and an RR operand bypass from the CDB is added.
// Payload field widths follow the ooo_pkg defaults.
module alu_exec_unit
   import ooo_pkg::*;
#(
   parameter int PHYS_REG_BITS = DEF_PHYS_REG_BITS,
   parameter int ROB_IDX_BITS  = DEF_ROB_IDX_BITS
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     issue_valid,
   input  logic [3:0]               issue_alu_op,
   input  logic                     issue_alu_src,
   input  logic [31:0]              issue_imm,
   input  logic [PHYS_REG_BITS-1:0] issue_phys_rs1,
   input  logic [PHYS_REG_BITS-1:0] issue_phys_rs2,
   input  logic [PHYS_REG_BITS-1:0] issue_phys_rd,
   input  logic [ROB_IDX_BITS-1:0]  issue_rob_idx,
   output logic                     issue_ack,
   output logic [PHYS_REG_BITS-1:0] prf_rs1_addr,
   output logic [PHYS_REG_BITS-1:0] prf_rs2_addr,
   input  logic [31:0]              prf_rs1_data,
   input  logic [31:0]              prf_rs2_data,
   output logic                     cdb_valid,
   input  logic                     cdb_ready,
   output logic [PHYS_REG_BITS-1:0] cdb_phys_rd,
   output logic [31:0]              cdb_data,
   output logic [ROB_IDX_BITS-1:0]  cdb_rob_idx,
   output logic                     wakeup_en,
   output logic [PHYS_REG_BITS-1:0] wakeup_phys_rd
);

   logic              vld_p0;
   logic              vld_p1;
   rr_payload_t       rr_p0;
   ex_payload_t       ex_p1;
   rr_payload_t       issue_pld;

   logic              cdb_fire;
   logic              ex_free;
   logic              rr_adv;

   logic [DATA_W-1:0] rs1_val;
   logic [DATA_W-1:0] rs2_val;
   logic [DATA_W-1:0] opb_sel;
   logic [DATA_W-1:0] alu_result;

   // Handshake: EX frees when empty or draining; RR moves when EX frees.
   assign cdb_valid = vld_p1 & ~flush;
   assign cdb_fire  = cdb_valid & cdb_ready;
   assign ex_free   = ~vld_p1 | cdb_fire;
   assign rr_adv    = vld_p0 & ex_free;
   assign issue_ack = issue_valid & ~flush & (~vld_p0 | rr_adv);

   assign issue_pld = '{op:      alu_op_e'(issue_alu_op),
                        alu_src: issue_alu_src,
                        imm:     issue_imm,
                        rs1:     issue_phys_rs1,
                        rs2:     issue_phys_rs2,
                        rd:      issue_phys_rd,
                        rob_idx: issue_rob_idx};

   // ---- RR stage: capture issued op, drive PRF read ports ----
   // RR valid bit and payload register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         rr_p0  <= '0;
      end else begin
         if (flush)          vld_p0 <= 1'b0;
         else if (issue_ack) vld_p0 <= 1'b1;
         else if (rr_adv)    vld_p0 <= 1'b0;
         if (issue_ack)      rr_p0  <= issue_pld;
      end
   end

   assign prf_rs1_addr = rr_p0.rs1;
   assign prf_rs2_addr = rr_p0.rs2;

   // Resolve source operands; p0 reads zero, optional bypass from the CDB.
   always_comb begin
      rs1_val = preg_value(rr_p0.rs1, prf_rs1_data);
      rs2_val = preg_value(rr_p0.rs2, prf_rs2_data);
`ifdef EARLY_WAKEUP_EN
      if (cdb_fire && (ex_p1.rd != '0) && (ex_p1.rd == rr_p0.rs1)) rs1_val = alu_result;
      if (cdb_fire && (ex_p1.rd != '0) && (ex_p1.rd == rr_p0.rs2)) rs2_val = alu_result;
`endif
      opb_sel = rr_p0.alu_src ? rr_p0.imm : rs2_val;
   end

   // ---- EX stage: hold operands until the CDB accepts the result ----
   // EX valid bit and payload register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         ex_p1  <= '0;
      end else begin
         if (flush)         vld_p1 <= 1'b0;
         else if (rr_adv)   vld_p1 <= 1'b1;
         else if (cdb_fire) vld_p1 <= 1'b0;
         if (rr_adv && !flush) begin
            ex_p1.op      <= rr_p0.op;
            ex_p1.opa     <= rs1_val;
            ex_p1.opb     <= opb_sel;
            ex_p1.rd      <= rr_p0.rd;
            ex_p1.rob_idx <= rr_p0.rob_idx;
         end
      end
   end

   ooo_alu u_alu (
      .op     (ex_p1.op),
      .a      (ex_p1.opa),
      .b      (ex_p1.opb),
      .result (alu_result)
   );

   assign cdb_data    = alu_result;
   assign cdb_phys_rd = ex_p1.rd;
   assign cdb_rob_idx = ex_p1.rob_idx;

`ifdef EARLY_WAKEUP_EN
   // Wake dependents as the producer leaves RR; the bypass covers the gap.
   assign wakeup_en      = rr_adv & ~flush & (rr_p0.rd != '0);
   assign wakeup_phys_rd = rr_p0.rd;
`else
   // Wake dependents when the result is accepted on the CDB.
   assign wakeup_en      = cdb_fire & (ex_p1.rd != '0);
   assign wakeup_phys_rd = ex_p1.rd;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a small behavioural PRF that is
// written on every accepted CDB beat.
module tb_alu_exec_unit;

   localparam int PRB = 6;
   localparam int RIB = 4;
`ifdef EARLY_WAKEUP_EN
   localparam bit EARLY = 1'b1;
   localparam int GAP   = 2;
`else
   localparam bit EARLY = 1'b0;
   localparam int GAP   = 3;
`endif

   logic           clk;
   logic           rst_n;
   logic           flush;
   logic           issue_valid;
   logic [3:0]     issue_alu_op;
   logic           issue_alu_src;
   logic [31:0]    issue_imm;
   logic [PRB-1:0] issue_phys_rs1;
   logic [PRB-1:0] issue_phys_rs2;
   logic [PRB-1:0] issue_phys_rd;
   logic [RIB-1:0] issue_rob_idx;
   logic           issue_ack;
   logic [PRB-1:0] prf_rs1_addr;
   logic [PRB-1:0] prf_rs2_addr;
   logic [31:0]    prf_rs1_data;
   logic [31:0]    prf_rs2_data;
   logic           cdb_valid;
   logic           cdb_ready;
   logic [PRB-1:0] cdb_phys_rd;
   logic [31:0]    cdb_data;
   logic [RIB-1:0] cdb_rob_idx;
   logic           wakeup_en;
   logic [PRB-1:0] wakeup_phys_rd;

   logic [31:0]    prf [64];
   int             fire_cyc [64];
   int             cyc;
   int             n_cmp;
   int             n_err;
   int             k;

   alu_exec_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .issue_valid    (issue_valid),
      .issue_alu_op   (issue_alu_op),
      .issue_alu_src  (issue_alu_src),
      .issue_imm      (issue_imm),
      .issue_phys_rs1 (issue_phys_rs1),
      .issue_phys_rs2 (issue_phys_rs2),
      .issue_phys_rd  (issue_phys_rd),
      .issue_rob_idx  (issue_rob_idx),
      .issue_ack      (issue_ack),
      .prf_rs1_addr   (prf_rs1_addr),
      .prf_rs2_addr   (prf_rs2_addr),
      .prf_rs1_data   (prf_rs1_data),
      .prf_rs2_data   (prf_rs2_data),
      .cdb_valid      (cdb_valid),
      .cdb_ready      (cdb_ready),
      .cdb_phys_rd    (cdb_phys_rd),
      .cdb_data       (cdb_data),
      .cdb_rob_idx    (cdb_rob_idx),
      .wakeup_en      (wakeup_en),
      .wakeup_phys_rd (wakeup_phys_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   assign prf_rs1_data = prf[prf_rs1_addr];
   assign prf_rs2_data = prf[prf_rs2_addr];

   // Behavioural PRF: p_i = 10*i at reset, p0 holds junk the DUT must ignore.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) prf[i] <= 32'(i * 10);
         prf[0]  <= 32'hDEAD_BEEF;
         prf[20] <= 32'h8000_0000;
         prf[21] <= 32'hFFFF_FFFF;
      end else if (cdb_valid && cdb_ready) begin
         fire_cyc[cdb_phys_rd] <= cyc;
         if (cdb_phys_rd != '0) prf[cdb_phys_rd] <= cdb_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_issue(input int op, input int src, input int imm,
                            input int rs1, input int rs2, input int rd, input int rob);
      issue_valid    = 1'b1;
      issue_alu_op   = 4'(op);
      issue_alu_src  = 1'(src);
      issue_imm      = 32'(imm);
      issue_phys_rs1 = PRB'(rs1);
      issue_phys_rs2 = PRB'(rs2);
      issue_phys_rd  = PRB'(rd);
      issue_rob_idx  = RIB'(rob);
   endtask

   // Issue one op into an idle pipe and check its CDB beat two edges later.
   task automatic run_op(input string tag, input int op, input int src, input int imm,
                         input int rs1, input int rs2, input int rd, input logic [31:0] exp);
      set_issue(op, src, imm, rs1, rs2, rd, 1);
      #1;
      tick();
      issue_valid = 1'b0;
      tick();
      check({tag, "_valid"}, 32'(cdb_valid), 1);
      check(tag, cdb_data, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 64; i++) fire_cyc[i] = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      cdb_ready = 1'b1;
      set_issue(0, 0, 0, 0, 0, 0, 0);
      #12;
      // Reset state
      check("rst_cdb_valid", 32'(cdb_valid), 0);
      check("rst_wakeup", 32'(wakeup_en), 0);
      check("rst_cdb_data", cdb_data, 0);
      check("rst_cdb_rd", 32'(cdb_phys_rd), 0);
      check("rst_cdb_rob", 32'(cdb_rob_idx), 0);
      check("rst_rs1_addr", 32'(prf_rs1_addr), 0);
      check("rst_rs2_addr", 32'(prf_rs2_addr), 0);
      check("rst_ack", 32'(issue_ack), 1);
      issue_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Basic ADD p5 = p1 + 7
      set_issue(0, 1, 7, 1, 0, 5, 3);
      #1;
      check("add_ack", 32'(issue_ack), 1);
      tick();
      issue_valid = 1'b0;
      #1;
      check("add_rr_no_valid", 32'(cdb_valid), 0);
      check("add_rr_addr", 32'(prf_rs1_addr), 1);
      check("add_rr_wakeup", 32'(wakeup_en), 32'(EARLY));
      tick();
      check("add_valid", 32'(cdb_valid), 1);
      check("add_data", cdb_data, 17);
      check("add_rd", 32'(cdb_phys_rd), 5);
      check("add_rob", 32'(cdb_rob_idx), 3);
      check("add_ex_wakeup", 32'(wakeup_en), 32'(!EARLY));
      tick();
      check("add_done", 32'(cdb_valid), 0);
      check("add_done_wakeup", 32'(wakeup_en), 0);

      // Backpressure: three ops with cdb_ready low
      cdb_ready = 1'b0;
      set_issue(0, 1, 1, 1, 0, 10, 4);
      #1;
      check("stall_ack_a", 32'(issue_ack), 1);
      tick();
      set_issue(0, 1, 2, 2, 0, 11, 5);
      #1;
      check("stall_ack_b", 32'(issue_ack), 1);
      tick();
      set_issue(0, 1, 3, 3, 0, 12, 6);
      #1;
      check("stall_ack_c0", 32'(issue_ack), 0);
      check("stall_hold_valid", 32'(cdb_valid), 1);
      check("stall_no_wakeup", 32'(wakeup_en), 0);
      tick();
      check("stall_ack_c1", 32'(issue_ack), 0);
      tick();
      check("stall_ack_c2", 32'(issue_ack), 0);
      check("stall_hold_data", cdb_data, 11);
      tick();
      cdb_ready = 1'b1;
      #1;
      check("release_ack_c", 32'(issue_ack), 1);
      check("release_a_data", cdb_data, 11);
      check("release_a_rd", 32'(cdb_phys_rd), 10);
      tick();
      issue_valid = 1'b0;
      #1;
      check("release_b_data", cdb_data, 22);
      check("release_b_rd", 32'(cdb_phys_rd), 11);
      tick();
      check("release_c_data", cdb_data, 33);
      check("release_c_rd", 32'(cdb_phys_rd), 12);
      tick();
      check("release_empty", 32'(cdb_valid), 0);

      // Dependent pair: p7 = p1 + p2, then p8 = p7 - 1 issued on wake-up
      set_issue(0, 0, 0, 1, 2, 7, 7);
      #1;
      tick();
      issue_valid = 1'b0;
      #1;
      k = 0;
      while (!(wakeup_en && wakeup_phys_rd == 6'd7) && k < 6) begin
         tick();
         k++;
      end
      check("dep_wakeup_seen", 32'(k < 6), 1);
      tick();
      set_issue(1, 1, 1, 7, 0, 8, 8);
      #1;
      check("dep_ack", 32'(issue_ack), 1);
      tick();
      issue_valid = 1'b0;
      #1;
      k = 0;
      while (!(cdb_valid && cdb_phys_rd == 6'd8) && k < 6) begin
         tick();
         k++;
      end
      check("dep_seen", 32'(k < 6), 1);
      check("dep_data", cdb_data, 29);
      tick();
      check("dep_prod_prf", prf[7], 30);
      check("dep_ex_gap", 32'(fire_cyc[8] - fire_cyc[7]), 32'(GAP));

      // Flush with RR and EX both occupied
      set_issue(0, 1, 0, 1, 0, 13, 9);
      #1;
      tick();
      set_issue(0, 1, 0, 2, 0, 14, 10);
      #1;
      tick();
      flush = 1'b1;
      #1;
      check("flush_valid", 32'(cdb_valid), 0);
      check("flush_wakeup", 32'(wakeup_en), 0);
      check("flush_ack", 32'(issue_ack), 0);
      tick();
      flush = 1'b0;
      issue_valid = 1'b0;
      #1;
      check("flush_next_valid", 32'(cdb_valid), 0);
      check("flush_next_wakeup", 32'(wakeup_en), 0);
      tick();
      check("flush_next2_valid", 32'(cdb_valid), 0);
      check("flush_prf_untouched", prf[13], 130);
      set_issue(4, 1, 32'hFF, 2, 0, 15, 11);
      #1;
      check("post_flush_ack", 32'(issue_ack), 1);
      tick();
      issue_valid = 1'b0;
      tick();
      check("post_flush_valid", 32'(cdb_valid), 1);
      check("post_flush_data", cdb_data, 32'hEB);
      check("post_flush_rd", 32'(cdb_phys_rd), 15);
      tick();

      // ALU corners and remaining operations
      run_op("sra", 7, 1, 31, 20, 0, 30, 32'hFFFF_FFFF);
      run_op("slt", 8, 1, 1, 21, 0, 31, 32'd1);
      run_op("sltu", 9, 1, 1, 21, 0, 32, 32'd0);
      run_op("op12", 12, 1, 5, 1, 0, 33, 32'd0);
      run_op("srl", 6, 1, 4, 20, 0, 34, 32'h0800_0000);
      run_op("sll", 5, 1, 3, 1, 0, 35, 32'd80);
      run_op("sub_rs2", 1, 0, 0, 2, 1, 36, 32'd10);
      run_op("and", 2, 1, 32'h0F0F, 21, 0, 37, 32'h0000_0F0F);
      run_op("or", 3, 1, 32'h100, 1, 0, 38, 32'h0000_010A);
      run_op("p0_reads_zero", 0, 1, 3, 0, 0, 39, 32'd3);
      run_op("sltu_rs2", 9, 0, 0, 1, 2, 40, 32'd1);
      tick();

      // Destination p0: CDB beat without wake-up
      set_issue(0, 1, 5, 1, 0, 0, 12);
      #1;
      tick();
      issue_valid = 1'b0;
      #1;
      check("p0_rr_wakeup", 32'(wakeup_en), 0);
      tick();
      check("p0_valid", 32'(cdb_valid), 1);
      check("p0_rd", 32'(cdb_phys_rd), 0);
      check("p0_data", cdb_data, 15);
      check("p0_wakeup", 32'(wakeup_en), 0);
      tick();

      // Asynchronous reset while a result is on the CDB
      set_issue(0, 1, 1, 1, 0, 23, 13);
      #1;
      tick();
      issue_valid = 1'b0;
      tick();
      check("midrst_pre_valid", 32'(cdb_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(cdb_valid), 0);
      check("midrst_rd", 32'(cdb_phys_rd), 0);
      check("midrst_data", cdb_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("midrst_after_valid", 32'(cdb_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Integer execute back-end fed directly by the issue queue. It accepts one issued ALU micro-op per cycle and reads its physical source operands in a register-read (RR) stage. It computes the result in an execute (EX) stage and delivers the result on a single common data bus (CDB) with valid/ready backpressure. It also produces the wake-up broadcast that the issue queue consumes.

## Interface
- PHYS_REG_BITS, 6, physical register index width
- ROB_IDX_BITS, 4, ROB index width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline kill (mispredict/exception)
- issue_valid  in  1  issue queue offers an instruction
- issue_alu_op  in  4  ALU operation
- issue_alu_src  in  1  0 = operand B from rs2, 1 = operand B from imm
- issue_imm  in  32  immediate
- issue_phys_rs1, issue_phys_rs2, issue_phys_rd  in  PHYS_REG_BITS each  physical source and destination registers
- issue_rob_idx  in  ROB_IDX_BITS  ROB tag
- issue_ack  out  1  instruction accepted this cycle
- prf_rs1_addr, prf_rs2_addr  out  PHYS_REG_BITS  PRF read addresses (combinational read)
- prf_rs1_data, prf_rs2_data  in  32  PRF read data, same cycle
- cdb_valid  out  1  result available
- cdb_ready  in  1  CDB arbiter accepts; the PRF write and ROB completion happen at this edge
- cdb_phys_rd  out  PHYS_REG_BITS  result destination
- cdb_data  out  32  result
- cdb_rob_idx  out  ROB_IDX_BITS  completing ROB entry
- wakeup_en  out  1  wake-up broadcast valid
- wakeup_phys_rd  out  PHYS_REG_BITS  register being woken

## Operation
- The block has two stages, RR and EX. Each stage has a valid bit plus a payload register.
- Fire signals:
  - cdb_fire = cdb_valid & cdb_ready
  - ex_free = !ex_valid | cdb_fire
  - rr_adv = rr_valid & ex_free
  - issue_ack = issue_valid & !flush & (!rr_valid | rr_adv)
- On issue_ack, the RR register captures the issue payload.
- On rr_adv, the EX register captures the payload plus operands:
  - opA = rs1 value.
  - opB = issue_alu_src ? imm : rs2 value.
  - Physical register 0 always reads as 0.
- The PRF addresses are driven from the RR payload every cycle.
- The EX stage computes the ALU result combinationally:
  - cdb_data = result.
  - cdb_valid = ex_valid & !flush.
- The EX stage holds its contents while cdb_ready is low. RR and issue stall behind it.
- ALU encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU.
  - Codes 10–15 produce 0.
  - Shift amount = opB[4:0].
  - SLT/SLTU produce 32'd0 or 32'd1.
  - All arithmetic is 32-bit, wrapping, with no flags.
- A destination of phys_rd 0 still fires on the CDB, but never raises wakeup_en.
- flush clears rr_valid and ex_valid at the edge. In the flush cycle, issue_ack, cdb_valid and wakeup_en are all forced to 0.

## Timing
- Reset: rr_valid = ex_valid = 0 and payloads zero. Therefore:
  - cdb_valid = 0, wakeup_en = 0, all cdb_* fields = 0.
  - prf addresses = 0.
  - issue_ack = issue_valid.
- Latency: issue accepted at edge t → RR in cycle t+1 → EX in t+2. cdb_valid rises in t+2 if there is no stall.
- Sustained throughput is 1 op/cycle while cdb_ready stays high.
- Default wake-up: wakeup_en = cdb_fire with phys_rd ≠ 0, and wakeup_phys_rd = cdb_phys_rd.
- A dependent instruction's EX stage is 3 cycles after its producer's EX stage.
- Simultaneous events:
  - An issue_ack and an rr_adv in the same cycle transfer without a bubble.
  - A cdb_fire and an rr_adv in the same cycle transfer without a bubble.
  - cdb_ready low for N cycles delays everything by exactly N cycles, with no loss or duplication.
- Reset asserted mid-operation clears everything immediately, with no partial CDB beat.

## Configuration
- EARLY_WAKEUP_EN defined:
  - wakeup_en = rr_adv & rr_phys_rd ≠ 0, with wakeup_phys_rd = RR payload phys_rd.
  - An RR→EX operand bypass is added: if cdb_fire and cdb_phys_rd matches rs1 (or rs2) and is ≠ 0, cdb_data replaces the PRF value.
  - A dependent instruction's EX stage is 2 cycles after its producer's EX stage.
- EARLY_WAKEUP_EN undefined: wake-up is taken from cdb_fire and there is no bypass mux.

## Structure
- Package ooo_pkg holds:
  - the alu_op_e enum (codes above)
  - PHYS_REG_BITS, ROB_IDX_BITS defaults
  - a packed rr_payload_t / ex_payload_t struct
- The sub-module ooo_alu is purely combinational (op, a, b → result). It is reused by future execution units.

## Test plan
- After reset, issue ADD p5 = p1 (10) + imm 7 with cdb_ready = 1 → issue_ack = 1; two edges later cdb_valid = 1, cdb_data = 17, cdb_phys_rd = 5, and wakeup_en is pulsed once.
- Hold cdb_ready = 0 for 4 cycles with 3 ops issued → issue_ack drops once RR and EX are full; after release, results appear in order with no duplicate or lost beat.
- Dependent pair: p7 = p1 + p2, then p8 = p7 SUB imm 1 → p8 result correct. Producer-to-consumer EX gap is 3 cycles (2 with EARLY_WAKEUP_EN).
- Assert flush while RR and EX are both valid → no cdb_valid in that cycle or the next; the next issued op completes normally.
- ALU corners: SRA 0x80000000 by 31 → 0xFFFFFFFF; SLT −1 < 1 → 1; SLTU 0xFFFFFFFF < 1 → 0; op 12 → 0; destination p0 → CDB beat with no wakeup.
